// File: rtl/msrv32_trap_controller_if.sv
// Trap-controller bus: decode/CSR status into the controller, trap controls back to the CSR file.
// The controller uses the slave modport; whatever drives decode and CSR status uses master.
interface msrv32_trap_controller_if;
    logic       illegal_instr_in;
    logic       misaligned_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic [4:0] opcode_6_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in;
    logic [4:0] rs2_addr_in;
    logic [4:0] rd_addr_in;
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       meip_in;
    logic       mtip_in;
    logic       msip_in;

    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_cause_out;
    logic       set_epc_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic       instret_inc_out;
    logic       misaligned_exception_out;
    logic [1:0] pc_src_out;
    logic       flush_out;
    logic       trap_taken_out;
    logic [1:0] fsm_state;

    modport slave (
        input  illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
               opcode_6_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
               instret_inc_out, misaligned_exception_out, pc_src_out, flush_out,
               trap_taken_out, fsm_state
    );

    modport master (
        output illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
               opcode_6_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
        input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
               instret_inc_out, misaligned_exception_out, pc_src_out, flush_out,
               trap_taken_out, fsm_state
    );
endinterface

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: takes interrupts/exceptions, executes mret and selects the next-PC source.
// Pulse outputs are registered from the next state, so each is exactly one glitch-free cycle wide.
module msrv32_trap_controller (
    input  logic                          clk_in,
    input  logic                          rst_in,
    msrv32_trap_controller_if.slave       bus
);
    typedef enum logic [1:0] {
        RESET       = 2'b00,
        OPERATING   = 2'b01,
        TRAP_TAKEN  = 2'b10,
        TRAP_RETURN = 2'b11
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       is_system;
    logic       is_ecall;
    logic       is_ebreak;
    logic       is_mret;
    logic       irq;
    logic       exc;
    logic       trap;
    logic       trap_is_irq;
    logic [3:0] trap_cause;

    always_comb begin
        is_system = (bus.opcode_6_2_in == 5'b11100) && (bus.funct3_in == 3'b000) &&
                    (bus.rs1_addr_in == 5'd0) && (bus.rd_addr_in == 5'd0);
        is_ecall  = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00000);
        is_ebreak = is_system && (bus.funct7_in == 7'b0000000) && (bus.rs2_addr_in == 5'b00001);
        is_mret   = is_system && (bus.funct7_in == 7'b0011000) && (bus.rs2_addr_in == 5'b00010);
        irq = bus.mie_in && ((bus.meie_in && bus.meip_in) || (bus.msie_in && bus.msip_in) ||
                             (bus.mtie_in && bus.mtip_in));
        exc = bus.illegal_instr_in || bus.misaligned_instr_in || bus.misaligned_load_in ||
              bus.misaligned_store_in || is_ecall || is_ebreak;
        trap        = irq || exc;
        trap_is_irq = irq;
        trap_cause  = 4'd0;
        // Interrupts outrank every exception; within each class the first match wins.
        if (irq) begin
            if (bus.meie_in && bus.meip_in)      trap_cause = 4'd11;
            else if (bus.msie_in && bus.msip_in) trap_cause = 4'd3;
            else                                 trap_cause = 4'd7;
        end else begin
            if (bus.misaligned_instr_in)         trap_cause = 4'd0;
            else if (bus.illegal_instr_in)       trap_cause = 4'd2;
            else if (is_ebreak)                  trap_cause = 4'd3;
            else if (is_ecall)                   trap_cause = 4'd11;
            else if (bus.misaligned_load_in)     trap_cause = 4'd4;
            else                                 trap_cause = 4'd6;
        end
    end

    always_comb begin
        next_state = OPERATING;
        case (state)
            OPERATING: begin
                if (trap)         next_state = TRAP_TAKEN;
                else if (is_mret) next_state = TRAP_RETURN;
                else              next_state = OPERATING;
            end
            default: next_state = OPERATING;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                        <= RESET;
            bus.pc_src_out               <= 2'b00;
            bus.flush_out                <= 1'b1;
            bus.set_cause_out            <= 1'b0;
            bus.set_epc_out              <= 1'b0;
            bus.mie_clear_out            <= 1'b0;
            bus.trap_taken_out           <= 1'b0;
            bus.mie_set_out              <= 1'b0;
            bus.cause_out                <= 4'd0;
            bus.i_or_e_out               <= 1'b0;
            bus.misaligned_exception_out <= 1'b0;
        end else begin
            state              <= next_state;
            bus.flush_out      <= (next_state != OPERATING);
            bus.set_cause_out  <= (next_state == TRAP_TAKEN);
            bus.set_epc_out    <= (next_state == TRAP_TAKEN);
            bus.mie_clear_out  <= (next_state == TRAP_TAKEN);
            bus.trap_taken_out <= (next_state == TRAP_TAKEN);
            bus.mie_set_out    <= (next_state == TRAP_RETURN);
            case (next_state)
                RESET:       bus.pc_src_out <= 2'b00;
                TRAP_RETURN: bus.pc_src_out <= 2'b01;
                TRAP_TAKEN:  bus.pc_src_out <= 2'b10;
                default:     bus.pc_src_out <= 2'b11;
            endcase
            if (next_state == TRAP_TAKEN) begin
                bus.cause_out                <= trap_cause;
                bus.i_or_e_out               <= trap_is_irq;
                bus.misaligned_exception_out <= !trap_is_irq &&
                    ((trap_cause == 4'd0) || (trap_cause == 4'd4) || (trap_cause == 4'd6));
            end
        end
    end

    assign bus.instret_inc_out = (state == OPERATING) && !trap;
    assign bus.fsm_state       = state;
endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Bench for msrv32_trap_controller: directed scenarios then randomized traffic against a
// cycle-level reference built from the trap priority tables.
module tb_msrv32_trap_controller;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    msrv32_trap_controller_if bus ();

    msrv32_trap_controller dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: phase 0 = reset, 1 = running, 2 = trap cycle, 3 = return cycle.
    int         m_phase;
    logic [3:0] m_cause;
    logic       m_ioe;
    logic       m_mis;
    logic [4:0] exp_q[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.illegal_instr_in    = 0;
        bus.misaligned_instr_in = 0;
        bus.misaligned_load_in  = 0;
        bus.misaligned_store_in = 0;
        bus.mie_in  = 0;
        bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
        bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
        set_instr(5);
    endtask

    // 0 random, 1 ecall, 2 ebreak, 3 mret, 4 mret with rd!=0, 5 addi
    task automatic set_instr(int kind);
        logic [31:0] w;
        case (kind)
            0:       w = $urandom;
            1:       w = 32'h00000073;
            2:       w = 32'h00100073;
            3:       w = 32'h30200073;
            4:       w = 32'h302000f3;
            default: w = 32'h00000013;
        endcase
        bus.funct7_in     = w[31:25];
        bus.rs2_addr_in   = w[24:20];
        bus.rs1_addr_in   = w[19:15];
        bus.funct3_in     = w[14:12];
        bus.rd_addr_in    = w[11:7];
        bus.opcode_6_2_in = w[6:2];
    endtask

    task automatic ref_request(output bit irq, output bit exc, output bit mret,
                               output bit ioe, output logic [3:0] cause);
        logic [31:0] w;
        bit          ireq[3];
        bit          ereq[6];
        int          icause[3] = '{11, 3, 7};
        int          ecause[6] = '{0, 2, 3, 11, 4, 6};
        w = {bus.funct7_in, bus.rs2_addr_in, bus.rs1_addr_in, bus.funct3_in,
             bus.rd_addr_in, bus.opcode_6_2_in, 2'b11};
        mret = (w == 32'h30200073);
        ireq = '{bus.meie_in & bus.meip_in, bus.msie_in & bus.msip_in, bus.mtie_in & bus.mtip_in};
        ereq = '{bus.misaligned_instr_in, bus.illegal_instr_in, w == 32'h00100073,
                 w == 32'h00000073, bus.misaligned_load_in, bus.misaligned_store_in};
        irq = 0; exc = 0; cause = 0;
        for (int i = 5; i >= 0; i--) if (ereq[i]) begin exc = 1; cause = 4'(ecause[i]); end
        if (bus.mie_in) for (int i = 2; i >= 0; i--) if (ireq[i]) begin irq = 1; cause = 4'(icause[i]); end
        ioe = irq;
    endtask

    // Check the current cycle against the reference, then advance one clock.
    task automatic cycle();
        bit         irq, exc, mret, ioe;
        logic [3:0] cause;
        logic [4:0] e;
        @(negedge clk);
        ref_request(irq, exc, mret, ioe, cause);
        check("pc_src", 32'(bus.pc_src_out), (m_phase == 0) ? 0 : (m_phase == 1) ? 3 : (m_phase == 2) ? 2 : 1);
        check("flush", 32'(bus.flush_out), 32'(m_phase != 1));
        check("set_cause", 32'(bus.set_cause_out), 32'(m_phase == 2));
        check("set_epc", 32'(bus.set_epc_out), 32'(m_phase == 2));
        check("mie_clear", 32'(bus.mie_clear_out), 32'(m_phase == 2));
        check("trap_taken", 32'(bus.trap_taken_out), 32'(m_phase == 2));
        check("mie_set", 32'(bus.mie_set_out), 32'(m_phase == 3));
        check("instret", 32'(bus.instret_inc_out), 32'(m_phase == 1 && !(irq || exc)));
        if (m_phase == 2 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trap_cause", 32'({bus.i_or_e_out, bus.cause_out}), 32'(e));
        end
        check("cause", 32'(bus.cause_out), 32'(m_cause));
        check("i_or_e", 32'(bus.i_or_e_out), 32'(m_ioe));
        check("misaligned", 32'(bus.misaligned_exception_out), 32'(m_mis));
        if (rst) begin
            m_phase = 0; m_cause = 0; m_ioe = 0; m_mis = 0;
            exp_q.delete();
        end else if (m_phase == 1 && (irq || exc)) begin
            m_phase = 2; m_cause = cause; m_ioe = ioe;
            m_mis = !ioe && (cause == 0 || cause == 4 || cause == 6);
            exp_q.push_back({ioe, cause});
        end else if (m_phase == 1 && mret) begin
            m_phase = 3;
        end else begin
            m_phase = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_phase = 0; m_cause = 0; m_ioe = 0; m_mis = 0;
        rst = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 0;
        cycle();
        cycle();

        // timer interrupt
        bus.mie_in = 1; bus.mtie_in = 1; bus.mtip_in = 1;
        cycle();
        clear_inputs();
        check("timer_cause", 32'(bus.cause_out), 32'd7);
        check("timer_ioe", 32'(bus.i_or_e_out), 32'd1);
        cycle(); cycle();

        // everything pending, interrupts enabled then disabled
        bus.mie_in = 1; bus.meie_in = 1; bus.msie_in = 1; bus.mtie_in = 1;
        bus.meip_in = 1; bus.msip_in = 1; bus.mtip_in = 1; bus.illegal_instr_in = 1;
        cycle();
        check("prio_irq", 32'({bus.i_or_e_out, bus.cause_out}), 32'h1b);
        cycle();
        bus.mie_in = 0;
        cycle();
        check("prio_exc", 32'({bus.i_or_e_out, bus.cause_out}), 32'h02);
        clear_inputs();
        cycle(); cycle();

        // misaligned load
        bus.misaligned_load_in = 1;
        cycle();
        clear_inputs();
        check("mis_load", 32'({bus.misaligned_exception_out, bus.cause_out}), 32'h14);
        cycle(); cycle();

        // mret alone, then with ecall-like collision via illegal, then near-miss
        set_instr(3);
        cycle();
        set_instr(5);
        check("mret_pc", 32'(bus.pc_src_out), 32'd1);
        cycle(); cycle();
        set_instr(3); bus.illegal_instr_in = 1;
        cycle();
        clear_inputs();
        cycle();
        set_instr(1);
        cycle();
        clear_inputs();
        check("ecall_cause", 32'(bus.cause_out), 32'd11);
        cycle();
        set_instr(4);
        cycle(); cycle();
        set_instr(2);
        cycle();
        clear_inputs();
        cycle();

        // reset during the trap cycle
        bus.misaligned_store_in = 1;
        cycle();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
        check("rst_mid_cause", 32'(bus.cause_out), 32'd0);
        cycle(); cycle();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.mie_in  = $urandom_range(0, 1);
            bus.meie_in = $urandom_range(0, 1);
            bus.msie_in = $urandom_range(0, 1);
            bus.mtie_in = $urandom_range(0, 1);
            bus.meip_in = ($urandom_range(0, 4) == 0);
            bus.msip_in = ($urandom_range(0, 4) == 0);
            bus.mtip_in = ($urandom_range(0, 4) == 0);
            bus.illegal_instr_in    = ($urandom_range(0, 11) == 0);
            bus.misaligned_instr_in = ($urandom_range(0, 11) == 0);
            bus.misaligned_load_in  = ($urandom_range(0, 11) == 0);
            bus.misaligned_store_in = ($urandom_range(0, 11) == 0);
            set_instr(int'($urandom_range(0, 5)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
